// File: rtl/mem_bus_arbiter.sv
// Single-owner arbiter for the data-memory bus shared by loads and committing stores.
// Optional MEM_ARB_FLUSH_EN adds a flush input that aborts an in-flight load.
module mem_bus_arbiter #(
  parameter int LOAD_CYCLES      = 3,
  parameter int STORE_CYCLES     = 2,
  parameter int MAX_STORE_STREAK = 4,
  parameter int TAG_W            = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_req,
  input  logic [TAG_W-1:0] load_tag,
  input  logic             store_req,
  input  logic [TAG_W-1:0] store_tag,
`ifdef MEM_ARB_FLUSH_EN
  input  logic             flush,
`endif
  output logic             load_grant,
  output logic             store_grant,
  output logic             bus_busy_with_load,
  output logic             bus_busy_with_store,
  output logic             load_done,
  output logic             store_done,
  output logic [TAG_W-1:0] done_tag,
  output logic [2:0]       store_streak,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] LOAD_BUSY  = 2'd1;
  localparam logic [1:0] STORE_BUSY = 2'd2;

  localparam int MAX_CYC = (LOAD_CYCLES > STORE_CYCLES) ? LOAD_CYCLES : STORE_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] LOAD_RELOAD  = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STORE_RELOAD = CNT_W'(STORE_CYCLES - 1);
  localparam logic [2:0] STREAK_LIM = (MAX_STORE_STREAK > 7) ? 3'd7 : 3'(MAX_STORE_STREAK);

  // Handshake: a requester holds req (and its tag) high until it sees the
  // one-cycle grant pulse; the tag is sampled only on the grant edge.
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [TAG_W-1:0] r_tag;
  logic [TAG_W-1:0] r_done_tag;
  logic [2:0]       r_streak;
  logic             r_load_grant, r_store_grant;
  logic             r_busy_load, r_busy_store;
  logic             r_load_done, r_store_done;

  logic w_flush, w_abort, w_load_eff, w_store_eff, w_pick_load, w_pick_store;

`ifdef MEM_ARB_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // A requester granted on the previous edge may still show req high; ignore it once.
  always_comb begin
    w_abort      = w_flush && (r_state == LOAD_BUSY);
    w_load_eff   = load_req && !r_load_grant && !w_flush;
    w_store_eff  = store_req && !r_store_grant;
    w_pick_load  = w_load_eff && (!w_store_eff || (r_streak >= STREAK_LIM));
    w_pick_store = w_store_eff && !w_pick_load;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_tag         <= '0;
      r_done_tag    <= '0;
      r_streak      <= '0;
      r_load_grant  <= 1'b0;
      r_store_grant <= 1'b0;
      r_busy_load   <= 1'b0;
      r_busy_store  <= 1'b0;
      r_load_done   <= 1'b0;
      r_store_done  <= 1'b0;
    end else begin
      r_load_grant  <= 1'b0;
      r_store_grant <= 1'b0;
      r_load_done   <= 1'b0;
      r_store_done  <= 1'b0;
      if (w_abort) begin
        r_state     <= IDLE;
        r_cnt       <= '0;
        r_busy_load <= 1'b0;
      end else if ((r_state != IDLE) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end else begin
        if (r_state == LOAD_BUSY) begin
          r_load_done <= 1'b1;
          r_done_tag  <= r_tag;
        end
        if (r_state == STORE_BUSY) begin
          r_store_done <= 1'b1;
          r_done_tag   <= r_tag;
        end
        if (w_pick_load) begin
          r_state      <= LOAD_BUSY;
          r_load_grant <= 1'b1;
          r_busy_load  <= 1'b1;
          r_busy_store <= 1'b0;
          r_cnt        <= LOAD_RELOAD;
          r_tag        <= load_tag;
          r_streak     <= '0;
        end else if (w_pick_store) begin
          r_state       <= STORE_BUSY;
          r_store_grant <= 1'b1;
          r_busy_load   <= 1'b0;
          r_busy_store  <= 1'b1;
          r_cnt         <= STORE_RELOAD;
          r_tag         <= store_tag;
          if (!w_load_eff)            r_streak <= '0;
          else if (r_streak != 3'd7)  r_streak <= r_streak + 3'd1;
        end else begin
          r_state      <= IDLE;
          r_busy_load  <= 1'b0;
          r_busy_store <= 1'b0;
          r_cnt        <= '0;
          if (!w_load_eff) r_streak <= '0;
        end
      end
    end
  end

  assign load_grant          = r_load_grant;
  assign store_grant         = r_store_grant;
  assign bus_busy_with_load  = r_busy_load;
  assign bus_busy_with_store = r_busy_store;
  assign load_done           = r_load_done;
  assign store_done          = r_store_done;
  assign done_tag            = r_done_tag;
  assign store_streak        = r_streak;
  assign dbg_state           = r_state;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Sequences and shares the single data-memory bus between the load unit and the commit stage's store path.
- Replaces the ad-hoc bus_busy_with_load / bus_busy_with_store flag juggling with one owner. It grants the bus, times fixed-latency occupancy, and reports completion tagged with the RoB index.
- Stores win by default so commit does not stall. A streak limit prevents load starvation.

Parameters:
LOAD_CYCLES, 3, bus occupancy per load access (>=1)
STORE_CYCLES, 2, bus occupancy per store access (>=1)
MAX_STORE_STREAK, 4, consecutive store grants allowed while a load waits (>=1)
TAG_W, 7, RoB index width (128-entry RoB)

Ports:
clock  in  1  system clock, posedge active
reset  in  1  asynchronous, active-low reset
load_req  in  1  load unit requests bus; held until load_grant seen
load_tag  in  TAG_W  RoB index of requesting load
store_req  in  1  commit stage requests bus for RoB head store; held until store_grant
store_tag  in  TAG_W  RoB index of committing store
load_grant  out  1  one-cycle pulse: load owns bus from this cycle
store_grant  out  1  one-cycle pulse: store owns bus from this cycle
bus_busy_with_load  out  1  level: load occupying bus
bus_busy_with_store  out  1  level: store occupying bus
load_done  out  1  one-cycle pulse: load access complete
store_done  out  1  one-cycle pulse: store complete; commit may retire head
done_tag  out  TAG_W  tag of access finishing with load_done/store_done
store_streak  out  3  current consecutive-store-grant count (debug)

Behaviour:
- Reset (reset=0, async): state IDLE, all pulses and busy flags 0, done_tag 0, counter 0, store_streak 0, captured tag 0.
- FSM states:
  - IDLE: bus free.
  - LOAD_BUSY: load owns bus.
  - STORE_BUSY: store owns bus.
- All outputs are registered.
- Arbitration is evaluated at a posedge when state is IDLE, or when the state is busy and the counter is 0 (fall-through).
- Arbitration decision:
  - Only store_req: grant store.
  - Only load_req: grant load.
  - Both: grant store unless store_streak >= MAX_STORE_STREAK; in that case grant load.
  - Neither: go to/stay IDLE.
- On a grant:
  - Pulse the matching grant output.
  - Set the matching busy flag, clear the other flag.
  - Load the counter with CYCLES-1.
  - Capture the tag.
- While busy and the counter is non-zero, each posedge decrements the counter.
- Completion: at the posedge where the state is busy and the counter is 0:
  - Pulse load_done or store_done for one cycle.
  - done_tag takes the captured tag.
  - Arbitration is evaluated on the same edge. Back-to-back ownership has no idle bubble; done and the next grant may be high in the same cycle.
  - If nothing is granted, busy flags clear and state becomes IDLE.
- Example, LOAD_CYCLES=3, req seen at edge E0:
  - load_grant high E0-E1.
  - bus_busy_with_load high E0-E3.
  - load_done high E3-E4.
- Streak counter:
  - Increments (saturating at 7) on a store grant while load_req is high.
  - Clears on any load grant.
  - Clears when load_req is low at an arbitration edge.
- Req masking: a requester's req is ignored on the edge directly after its own grant, so a still-high req with CYCLES=1 is not granted twice.
- Requests arriving mid-occupancy wait. They are never dropped.
- Tags are held only while req is high; they are sampled only on the grant edge.
- Mutual exclusion: bus_busy_with_load and bus_busy_with_store are never both 1; load_grant and store_grant are never both 1.
- Reset mid-operation: the access is abandoned, no done pulse is issued, and requesters must re-request.

Optional Feature:
- MEM_ARB_FLUSH_EN defined:
  - Adds input flush (1 bit).
  - flush high at a posedge during LOAD_BUSY aborts the load: no load_done, state goes to IDLE, re-arbitration happens on the following edge.
  - flush also masks load_req at that edge.
  - flush has no effect on STORE_BUSY; committed stores always complete.
- Undefined: no flush port; loads always run to completion.

Test Plan:
- Single load, tag 5, LOAD_CYCLES=3: load_grant at E0, busy_with_load E0-E3, load_done at E3 with done_tag=5.
- Simultaneous load_req (tag 9) and store_req (tag 12): store granted first. store_done tag 12 at E2, load_grant in the same cycle, load_done tag 9 at E5.
- Continuous store_req plus waiting load, MAX_STORE_STREAK=4: four store grants, then a load grant. store_streak reads 4 then 0.
- CYCLES=1, req held high for 2 cycles: exactly one grant and one done, no duplicate grant.
- Async reset asserted mid-store (counter=1): all outputs 0 immediately, no store_done after release.
- MEM_ARB_FLUSH_EN: flush during a load's second cycle -> no load_done, and a pending store is granted on the next edge.
